// File: rtl/uart_fifo_pkg.sv
// ============================================================================
// uart_fifo_pkg : shared types, defaults and helpers for the UART2AXI FIFO.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package uart_fifo_pkg;

  localparam int unsigned c_DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned c_DEFAULT_FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo_strobe_edge.sv
// ============================================================================
// uart_fifo_strobe_edge : 2-flop synchroniser with rising-edge detector; one
//                         single-cycle pulse per 0->1 transition of strobe_i.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_strobe_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= strobe_i;
      sync2_q <= sync1_q;
    end
  end

  assign pulse_o = sync1_q & ~sync2_q;

endmodule

`default_nettype wire

// File: rtl/uart_param_fifo.sv
// ============================================================================
// uart_param_fifo : parametrised show-ahead FIFO with occupancy, thresholds,
//                   sticky errors, flush and ack pulses. Define
//                   UART_FIFO_EDGE_TRIG_EN for edge-triggered push/pop strobes.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module uart_param_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = c_DEFAULT_FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                              pi_clk,
  input  logic                              pi_rst,
  input  logic [DATA_WIDTH-1:0]             pi_data,
  input  logic                              pi_write_en,
  input  logic                              pi_read_en,
  input  logic                              pi_flush,
  input  logic                              pi_clr_err,
  output logic [DATA_WIDTH-1:0]             po_data,
  output logic [cnt_width(FIFO_DEPTH)-1:0]  po_count,
  output logic                              po_fifo_full,
  output logic                              po_fifo_empty,
  output logic                              po_almost_full,
  output logic                              po_almost_empty,
  output logic                              po_write_over,
  output logic                              po_read_over,
  output logic                              po_overflow,
  output logic                              po_underflow
);

  localparam int unsigned        CNT_W     = cnt_width(FIFO_DEPTH);
  localparam int unsigned        PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   AF_CNT    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]   AE_CNT    = CNT_W'(AE_THRESH);

  logic                  push_req, pop_req, push_ok, pop_ok;
  logic                  ovf_evt, udf_evt;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  wr_ack_q, rd_ack_q, ovf_q, ovf_d, udf_q, udf_d;

`ifdef UART_FIFO_EDGE_TRIG_EN
  uart_fifo_strobe_edge u_wr_edge (
    .clk_i    (pi_clk),
    .rst_ni   (pi_rst),
    .strobe_i (pi_write_en),
    .pulse_o  (push_req)
  );

  uart_fifo_strobe_edge u_rd_edge (
    .clk_i    (pi_clk),
    .rst_ni   (pi_rst),
    .strobe_i (pi_read_en),
    .pulse_o  (pop_req)
  );
`else
  assign push_req = pi_write_en;
  assign pop_req  = pi_read_en;
`endif

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign pop_ok  = !pi_flush && pop_req && !flags_q.empty;
  assign push_ok = !pi_flush && push_req && (!flags_q.full || pop_ok);
  assign ovf_evt = !pi_flush && push_req && !push_ok;
  assign udf_evt = !pi_flush && pop_req && flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (pi_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    flags_d.full         = (count_d == DEPTH_CNT);
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= AF_CNT);
    flags_d.almost_empty = (count_d <= AE_CNT);
    // A new error in the clearing cycle keeps the flag set.
    ovf_d = (ovf_q & ~pi_clr_err) | ovf_evt;
    udf_d = (udf_q & ~pi_clr_err) | udf_evt;
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst && push_ok) mem_q[wr_ptr_q] <= pi_data;
  end

  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      wr_ack_q <= push_ok;
      rd_ack_q <= pop_ok;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign po_data         = flags_q.empty ? '0 : mem_q[rd_ptr_q];
  assign po_count        = count_q;
  assign po_fifo_full    = flags_q.full;
  assign po_fifo_empty   = flags_q.empty;
  assign po_almost_full  = flags_q.almost_full;
  assign po_almost_empty = flags_q.almost_empty;
  assign po_write_over   = wr_ack_q;
  assign po_read_over    = rd_ack_q;
  assign po_overflow     = ovf_q;
  assign po_underflow    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_param_fifo.sv
// ============================================================================
// tb_uart_param_fifo : directed self-checking bench for uart_param_fifo
//                      (DEPTH=5, AF=4, AE=1).
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_uart_param_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] dout;
  logic [2:0] count;
  logic       full, empty, afull, aempty, wr_ack, rd_ack, ovf, udf;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_param_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (5),
    .AF_THRESH  (4),
    .AE_THRESH  (1)
  ) dut (
    .pi_clk          (clk),
    .pi_rst          (rst_n),
    .pi_data         (din),
    .pi_write_en     (wr_en),
    .pi_read_en      (rd_en),
    .pi_flush        (flush),
    .pi_clr_err      (clr_err),
    .po_data         (dout),
    .po_count        (count),
    .po_fifo_full    (full),
    .po_fifo_empty   (empty),
    .po_almost_full  (afull),
    .po_almost_empty (aempty),
    .po_write_over   (wr_ack),
    .po_read_over    (rd_ack),
    .po_overflow     (ovf),
    .po_underflow    (udf)
  );

  wire [6:0] st = {count, full, empty, afull, aempty};

  // Expected {count, full, empty, almost_full, almost_empty} for DEPTH=5, AF=4, AE=1.
  function automatic logic [6:0] exp_st(input int c);
    return {3'(c), (c == 5), (c == 0), (c >= 4), (c <= 1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; din = 8'h00; idle();
    step(); step();
    n_total++; if (st !== exp_st(0)) $display("FAIL reset_status got=%h exp=%h", st, exp_st(0)); else n_pass++;
    n_total++; if ({dout, wr_ack, rd_ack, ovf, udf} !== 12'h000) $display("FAIL reset_outs got=%h exp=000", {dout, wr_ack, rd_ack, ovf, udf});
    else n_pass++;
    rst_n = 1;
    step();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      din = 8'hA1 + 8'(i); wr_en = 1;
      step();
      n_total++; if (st !== exp_st(i + 1)) $display("FAIL fill_status[%0d] got=%h exp=%h", i, st, exp_st(i + 1)); else n_pass++;
      n_total++; if ({dout, wr_ack} !== {8'hA1, 1'b1}) $display("FAIL fill_head[%0d] got=%h/%b exp=a1/1", i, dout, wr_ack); else n_pass++;
    end
    wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (dout !== 8'hA1 + 8'(i)) $display("FAIL drain_data[%0d] got=%h exp=%h", i, dout, 8'hA1 + 8'(i)); else n_pass++;
      rd_en = 1;
      step();
      n_total++; if ({rd_ack, st} !== {1'b1, exp_st(4 - i)}) $display("FAIL drain_status[%0d] got=%h exp=%h", i, {rd_ack, st}, {1'b1, exp_st(4 - i)});
      else n_pass++;
    end
    rd_en = 0;
    n_total++; if (dout !== 8'h00) $display("FAIL drain_empty_data got=%h exp=00", dout); else n_pass++;
    step();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      din = 8'h10 + 8'(i); wr_en = 1;
      step();
    end
    din = 8'hFF;
    step();
    wr_en = 0;
    n_total++; if ({ovf, wr_ack, st} !== {2'b10, exp_st(5)}) $display("FAIL overflow_set got=%h exp=%h", {ovf, wr_ack, st}, {2'b10, exp_st(5)});
    else n_pass++;
    step();
    n_total++; if (ovf !== 1'b1) $display("FAIL overflow_sticky got=%b exp=1", ovf); else n_pass++;
    clr_err = 1;
    step();
    clr_err = 0;
    n_total++; if (ovf !== 1'b0) $display("FAIL overflow_clear got=%b exp=0", ovf); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    din = 8'h77; wr_en = 1; rd_en = 1;
    step();
    idle();
    n_total++; if ({wr_ack, rd_ack, ovf, st} !== {3'b110, exp_st(5)})
      $display("FAIL full_pushpop got=%h exp=%h", {wr_ack, rd_ack, ovf, st}, {3'b110, exp_st(5)}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      automatic logic [7:0] e = (i == 4) ? 8'h77 : 8'h11 + 8'(i);
      n_total++; if (dout !== e) $display("FAIL full_pushpop_order[%0d] got=%h exp=%h", i, dout, e); else n_pass++;
      rd_en = 1;
      step();
    end
    rd_en = 0;
    n_total++; if (st !== exp_st(0)) $display("FAIL full_pushpop_empty got=%h exp=%h", st, exp_st(0)); else n_pass++;
  endtask

  task automatic test_underflow();
    rd_en = 1;
    step();
    rd_en = 0;
    n_total++; if ({udf, rd_ack, st} !== {2'b10, exp_st(0)}) $display("FAIL underflow_set got=%h exp=%h", {udf, rd_ack, st}, {2'b10, exp_st(0)});
    else n_pass++;
    clr_err = 1;
    step();
    clr_err = 0;
    n_total++; if (udf !== 1'b0) $display("FAIL underflow_clear got=%b exp=0", udf); else n_pass++;
    din = 8'h3C; wr_en = 1; rd_en = 1;
    step();
    idle();
    n_total++; if ({dout, udf, wr_ack, rd_ack, st} !== {8'h3C, 3'b110, exp_st(1)})
      $display("FAIL empty_pushpop got=%h exp=%h", {dout, udf, wr_ack, rd_ack, st}, {8'h3C, 3'b110, exp_st(1)}); else n_pass++;
    rd_en = 1;
    step();
    clr_err = 1;
    step();
    idle();
    n_total++; if ({udf, st} !== {1'b1, exp_st(0)}) $display("FAIL clr_vs_new_err got=%h exp=%h", {udf, st}, {1'b1, exp_st(0)}); else n_pass++;
    clr_err = 1;
    step();
    clr_err = 0;
    n_total++; if (udf !== 1'b0) $display("FAIL underflow_clear2 got=%b exp=0", udf); else n_pass++;
  endtask

  task automatic test_flags_wrap();
    logic [1:0] ops [20] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10,
                             2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [7:0] q [$];
    logic       p_ok, w_ok;
    logic [7:0] e_data;
    for (int i = 0; i < 20; i++) begin
      p_ok = ops[i][0] && (q.size() > 0);
      w_ok = ops[i][1] && (q.size() < 5 || p_ok);
      din = 8'h40 + 8'(i); wr_en = ops[i][1]; rd_en = ops[i][0];
      if (p_ok) void'(q.pop_front());
      if (w_ok) q.push_back(din);
      step();
      e_data = (q.size() > 0) ? q[0] : 8'h00;
      n_total++; if (st !== exp_st(q.size())) $display("FAIL wrap_status[%0d] got=%h exp=%h", i, st, exp_st(q.size())); else n_pass++;
      n_total++; if (dout !== e_data) $display("FAIL wrap_data[%0d] got=%h exp=%h", i, dout, e_data); else n_pass++;
      n_total++; if ({wr_ack, rd_ack} !== {w_ok, p_ok}) $display("FAIL wrap_acks[%0d] got=%b%b exp=%b%b", i, wr_ack, rd_ack, w_ok, p_ok);
      else n_pass++;
    end
    idle();
    clr_err = 1;
    step();
    clr_err = 0;
  endtask

  task automatic test_flush_edge();
    rd_en = 1; step(); rd_en = 0; step(); step();
    for (int i = 0; i < 3; i++) begin
      din = 8'h20 + 8'(i); wr_en = 1; step(); wr_en = 0; step(); step();
    end
    n_total++; if ({udf, st} !== {1'b1, exp_st(3)}) $display("FAIL preflush got=%h exp=%h", {udf, st}, {1'b1, exp_st(3)}); else n_pass++;
    flush = 1;
`ifndef UART_FIFO_EDGE_TRIG_EN
    wr_en = 1; rd_en = 1;
`endif
    step();
    idle();
    n_total++; if ({dout, wr_ack, rd_ack, udf, st} !== {8'h00, 3'b001, exp_st(0)})
      $display("FAIL flush got=%h exp=%h", {dout, wr_ack, rd_ack, udf, st}, {8'h00, 3'b001, exp_st(0)}); else n_pass++;
    din = 8'h5A; wr_en = 1;
`ifdef UART_FIFO_EDGE_TRIG_EN
    step();
    n_total++; if (count !== 3'd0) $display("FAIL edge_latency got=%0d exp=0", count); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      step();
      n_total++; if (count !== 3'd1) $display("FAIL edge_single[%0d] got=%0d exp=1", i, count); else n_pass++;
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (count !== 3'(i + 1)) $display("FAIL level_hold[%0d] got=%0d exp=%0d", i, count, i + 1); else n_pass++;
    end
`endif
    wr_en = 0;
    step();
    n_total++; if (dout !== 8'h5A) $display("FAIL hold_data got=%h exp=5a", dout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rd_en = 1; step(); rd_en = 0; step(); step();
    n_total++; if (udf !== 1'b1) $display("FAIL premid_udf got=%b exp=1", udf); else n_pass++;
    din = 8'hEE; wr_en = 1;
    #2 rst_n = 0;
    #1;
    n_total++; if ({dout, wr_ack, rd_ack, ovf, udf, st} !== {12'h000, exp_st(0)})
      $display("FAIL reset_mid got=%h exp=%h", {dout, wr_ack, rd_ack, ovf, udf, st}, {12'h000, exp_st(0)}); else n_pass++;
    step();
    wr_en = 0; rst_n = 1;
    step(); step(); step();
    n_total++; if (st !== exp_st(0)) $display("FAIL reset_mid_after got=%h exp=%h", st, exp_st(0)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_flags_wrap();
    test_flush_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
